// File: rtl/fu_branch_target_buffer_if.sv
// Fetch-unit / branch-predictor interface: lookup request, prediction, and resolved-branch update.
interface fu_branch_target_buffer_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] pc;
  logic              predicted_outcome;
  logic [WORD_W-1:0] predicted_target;
  logic              update_btb;
  logic [WORD_W-1:0] update_pc;
  logic              branch_outcome;
  logic [WORD_W-1:0] branch_target;

  modport master (
    output pc, update_btb, update_pc, branch_outcome, branch_target,
    input  predicted_outcome, predicted_target
  );

  modport slave (
    input  pc, update_btb, update_pc, branch_outcome, branch_target,
    output predicted_outcome, predicted_target
  );
endinterface

// File: rtl/fu_branch_target_buffer.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Zero-latency lookup; resolved branches update the table on the clock edge.
module fu_branch_target_buffer #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned WORD_W  = 32
) (
  input logic                      CLK,
  input logic                      RST,
  fu_branch_target_buffer_if.slave bp
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [WORD_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign lk_idx = bp.pc[IDX_W+1:2];
  assign lk_tag = bp.pc[WORD_W-1:IDX_W+2];
  assign up_idx = bp.update_pc[IDX_W+1:2];
  assign up_tag = bp.update_pc[WORD_W-1:IDX_W+2];

  always_comb begin
    lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    bp.predicted_outcome = lk_hit && ctr_q[lk_idx][1];
    bp.predicted_target  = bp.predicted_outcome ? target_q[lk_idx]
                                                : bp.pc + WORD_W'(4);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bp.update_btb) begin
      if (up_hit) begin
        if (bp.branch_outcome) begin
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
          target_q[up_idx] <= bp.branch_target;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
        end
      end else if (bp.branch_outcome) begin
        // Taken miss replaces whatever entry aliases to this index.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bp.branch_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_fu_branch_target_buffer.sv
// Directed bench for fu_branch_target_buffer with hand-computed expectations.
module tb_fu_branch_target_buffer;
  logic CLK = 1'b0;
  logic RST;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fu_branch_target_buffer_if #(.WORD_W(32)) bp ();

  fu_branch_target_buffer #(.ENTRIES(16), .WORD_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bp  (bp.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_out, input logic [31:0] exp_tgt);
    @(negedge CLK);
    bp.update_btb = 1'b0;
    bp.pc = pc;
    #1;
    check_eq({tag, ".out"}, {31'd0, bp.predicted_outcome}, {31'd0, exp_out});
    check_eq({tag, ".tgt"}, bp.predicted_target, exp_tgt);
  endtask

  task automatic update(input logic [31:0] upc, input logic taken, input logic [31:0] tgt);
    @(negedge CLK);
    bp.update_btb     = 1'b1;
    bp.update_pc      = upc;
    bp.branch_outcome = taken;
    bp.branch_target  = tgt;
    @(posedge CLK);
    #1;
    bp.update_btb = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    bp.pc = '0;
    bp.update_btb = 1'b0;
    bp.update_pc = '0;
    bp.branch_outcome = 1'b0;
    bp.branch_target = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    lookup("rst_100", 32'h0000_0100, 1'b0, 32'h0000_0104);
    lookup("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Allocation then counter training at 0x100
    update(32'h100, 1'b1, 32'h200);
    lookup("alloc", 32'h100, 1'b1, 32'h200);
    update(32'h100, 1'b1, 32'h200);
    lookup("ctr11", 32'h100, 1'b1, 32'h200);
    update(32'h100, 1'b0, 32'hBAD0);
    lookup("nt_10", 32'h100, 1'b1, 32'h200);
    update(32'h100, 1'b0, 32'hBAD0);
    lookup("nt_01", 32'h100, 1'b0, 32'h104);
    update(32'h100, 1'b0, 32'hBAD0);
    update(32'h100, 1'b0, 32'hBAD0);
    update(32'h100, 1'b1, 32'h200);
    lookup("sat00_t01", 32'h100, 1'b0, 32'h104);
    update(32'h100, 1'b1, 32'h200);
    lookup("t_10", 32'h100, 1'b1, 32'h200);
    // Saturate high: 10 -> 11 -> 11 -> 11, NT keeps old target
    update(32'h100, 1'b1, 32'h200);
    update(32'h100, 1'b1, 32'h200);
    update(32'h100, 1'b1, 32'h200);
    update(32'h100, 1'b0, 32'hBAD0);
    lookup("sat11_nt", 32'h100, 1'b1, 32'h200);
    update(32'h100, 1'b0, 32'hBAD0);
    lookup("sat11_nt2", 32'h100, 1'b0, 32'h104);

    // Alias replacement at index 0
    update(32'h100, 1'b1, 32'h200);
    lookup("pre_alias", 32'h100, 1'b1, 32'h200);
    update(32'h140, 1'b1, 32'h300);
    lookup("alias_old", 32'h100, 1'b0, 32'h104);
    lookup("alias_new", 32'h140, 1'b1, 32'h300);

    // Not-taken miss never allocates
    update(32'h180, 1'b0, 32'h400);
    lookup("ntmiss", 32'h180, 1'b0, 32'h184);
    lookup("ntmiss_keep", 32'h140, 1'b1, 32'h300);

    // Same-cycle lookup and update: no bypass
    do_reset();
    @(negedge CLK);
    bp.pc             = 32'h100;
    bp.update_btb     = 1'b1;
    bp.update_pc      = 32'h100;
    bp.branch_outcome = 1'b1;
    bp.branch_target  = 32'h200;
    #1;
    check_eq("same_cyc.out", {31'd0, bp.predicted_outcome}, 32'd0);
    check_eq("same_cyc.tgt", bp.predicted_target, 32'h104);
    @(posedge CLK);
    #1;
    bp.update_btb = 1'b0;
    lookup("next_cyc", 32'h100, 1'b1, 32'h200);

    // Distinct index, low address bits ignored
    update(32'h104, 1'b1, 32'h500);
    lookup("idx1", 32'h104, 1'b1, 32'h500);
    lookup("idx0_keep", 32'h100, 1'b1, 32'h200);
    lookup("lowbits", 32'h102, 1'b1, 32'h200);

    // Reset beats concurrent update
    @(negedge CLK);
    RST               = 1'b1;
    bp.update_btb     = 1'b1;
    bp.update_pc      = 32'h140;
    bp.branch_outcome = 1'b1;
    bp.branch_target  = 32'h300;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    bp.update_btb = 1'b0;
    lookup("rst_100b", 32'h100, 1'b0, 32'h104);
    lookup("rst_104b", 32'h104, 1'b0, 32'h108);
    lookup("rst_140b", 32'h140, 1'b0, 32'h144);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
